// File: rtl/uart_cmd_decoder.sv
// Turns received UART command blocks into register-file writes and reads.
// Read data is streamed back to the UART transmitter over a valid/ready handshake.
module uart_cmd_decoder #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_block_timeout,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_RD_LEN  = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_SEND = 3'd5
  } state_e;

  localparam int                WAIT_W    = 3;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // State, counters and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= 8'd0;
      wait_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      reg_addr_q <= '0;
      wdata_q    <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wait_q     <= wait_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output decode; strobes default low, data outputs hold.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wait_d     = wait_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_data_valid) begin
          addr_d  = rx_data[ADDR_W-1:0];
          state_d = rx_data[7] ? S_RD_LEN : S_WR_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WR_DATA: begin
        // A byte arriving with the timeout is still written before leaving.
        if (rx_data_valid) begin
          wr_en_d    = 1'b1;
          reg_addr_d = addr_q;
          wdata_d    = rx_data;
          addr_d     = addr_q + ADDR_ONE;
        end else begin
          wr_en_d = 1'b0;
        end
        if (rx_block_timeout) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_DATA;
        end
      end

      S_RD_LEN: begin
        if (rx_data_valid) begin
          len_d = rx_data;
          if (rx_data == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_RD_REQ;
            rd_en_d    = 1'b1;
            reg_addr_d = addr_q;
          end
        end else if (rx_block_timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_LEN;
        end
      end

      S_RD_REQ: begin
        // reg_rd_en is high during this state; latency counting starts next.
        err_d   = rx_data_valid;
        wait_d  = WAIT_ONE;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        err_d = rx_data_valid;
        if (wait_q == WAIT_LAST) begin
          tx_valid_d = 1'b1;
          tx_data_d  = reg_rdata;
          state_d    = S_RD_SEND;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_RD_SEND: begin
        err_d = rx_data_valid;
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + ADDR_ONE;
          len_d      = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_RD_REQ;
            rd_en_d    = 1'b1;
            reg_addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = S_RD_SEND;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = wdata_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed table, hand sequences,
// and randomized command blocks scored against a transaction-level model.
module tb_uart_cmd_decoder;

  localparam int ADDR_W = 7;
  localparam int RD_LAT = 2;
  localparam int NVEC   = 7;

  logic              clk;
  logic              rst_n;
  logic              rx_data_valid;
  logic [7:0]        rx_data;
  logic              rx_block_timeout;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              err;

  uart_cmd_decoder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data_valid    (rx_data_valid),
    .rx_data          (rx_data),
    .rx_block_timeout (rx_block_timeout),
    .reg_wr_en        (reg_wr_en),
    .reg_rd_en        (reg_rd_en),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_rdata        (reg_rdata),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit ready_rand = 1'b0;

  // Observed transactions, collected at the falling edge.
  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];
  int          n_tx = 0;
  int          n_err = 0;
  int          cyc = 0;

  // Expected transactions for the random phase.
  logic [14:0] exp_wr_q[$];
  logic [6:0]  exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];

  function automatic logic [7:0] rdata_of(input logic [6:0] a);
    return 8'h40 + {1'b0, a};
  endfunction

  // Register file: data appears RD_LAT cycles after a read strobe, junk otherwise.
  logic [7:0] rd_pipe [0:3];
  always @(negedge clk) begin
    rd_pipe[0] <= reg_rd_en ? rdata_of(reg_addr) : 8'hFF;
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    reg_rdata <= rd_pipe[RD_LAT-1];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (reg_wr_en) wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd_en) rd_q.push_back(reg_addr);
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        tx_cyc.push_back(cyc);
        n_tx <= n_tx + 1;
      end
      if (err) n_err <= n_err + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) tx_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic to);
    rx_data_valid = 1'b1;
    rx_data = b;
    rx_block_timeout = to;
    tick();
    rx_data_valid = 1'b0;
    rx_block_timeout = 1'b0;
  endtask

  task automatic send_to();
    rx_block_timeout = 1'b1;
    tick();
    rx_block_timeout = 1'b0;
  endtask

  task automatic wait_tx(input int target, input string name);
    int k;
    k = 0;
    while (n_tx < target && k < 2000) begin
      tick();
      k++;
    end
    chk({name, "_tx_done"}, n_tx, target);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!tx_valid && k < 50) begin
      tick();
      k++;
    end
    chk({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic clear_obs();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    tx_cyc.delete();
  endtask

  typedef struct packed {
    logic [2:0]  nb;        // number of bytes in the block
    logic [39:0] bytes;     // first byte in the top 8 bits
    logic        to;        // timeout after the bytes
    logic [7:0]  exp_wr;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_tx;
    logic [7:0]  exp_err;
    logic [7:0]  exp_last;  // last written data or last transmitted byte
    logic [6:0]  exp_addr;  // address of the last write or read
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    logic [39:0] bb;
    int base_err, tgt, kind, k, len, ai;
    logic [6:0] a;
    logic [7:0] d;
    bit coin;

    vecs[0] = '{3'd4, {8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 1'b1, 8'd3, 8'd0, 8'd0, 8'd0, 8'hCC, 7'h12};
    vecs[1] = '{3'd2, {8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 7'h00};
    vecs[2] = '{3'd4, {8'h7E, 8'h01, 8'h02, 8'h03, 8'h00}, 1'b1, 8'd3, 8'd0, 8'd0, 8'd0, 8'h03, 7'h00};
    vecs[3] = '{3'd1, {8'h90, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd0, 8'd0, 8'd1, 8'h00, 7'h00};
    vecs[4] = '{3'd2, {8'h85, 8'h03, 8'h00, 8'h00, 8'h00}, 1'b0, 8'd0, 8'd3, 8'd3, 8'd0, 8'h47, 7'h07};
    vecs[5] = '{3'd0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 7'h00};
    vecs[6] = '{3'd2, {8'h01, 8'h99, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd1, 8'd0, 8'd0, 8'd0, 8'h99, 7'h01};

    rst_n = 1'b0;
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    rx_block_timeout = 1'b0;
    tx_ready = 1'b0;
    #1;
    chk("reset_outputs", {4'd0, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, tx_data, busy, err}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tx_ready = 1'b1;

    // Write strobe latency, busy timing, and byte coinciding with timeout.
    send_byte(8'h10, 1'b0);
    chk("wr_busy_high", {31'd0, busy}, 32'd1);
    rx_data_valid = 1'b1;
    rx_data = 8'hAA;
    tick();
    rx_data_valid = 1'b0;
    chk("wr_strobe", {31'd0, reg_wr_en}, 32'd1);
    chk("wr_strobe_addr", {25'd0, reg_addr}, 32'h10);
    chk("wr_strobe_data", {24'd0, reg_wdata}, 32'hAA);
    tick();
    chk("wr_strobe_single", {31'd0, reg_wr_en}, 32'd0);
    rx_block_timeout = 1'b1;
    chk("wr_busy_before_to", {31'd0, busy}, 32'd1);
    tick();
    rx_block_timeout = 1'b0;
    chk("wr_busy_after_to", {31'd0, busy}, 32'd0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h77, 1'b1);
    chk("coinc_wr", {31'd0, reg_wr_en}, 32'd1);
    chk("coinc_wr_addr_data", {17'd0, reg_addr, reg_wdata}, {17'd0, 7'h20, 8'h77});
    chk("coinc_idle", {31'd0, busy}, 32'd0);
    repeat (2) tick();

    // Directed table.
    for (int v = 0; v < NVEC; v++) begin
      clear_obs();
      base_err = n_err;
      tgt = n_tx + int'(vecs[v].exp_tx);
      bb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].nb); i++) send_byte(bb[39-8*i -: 8], 1'b0);
      if (vecs[v].to) send_to();
      if (vecs[v].exp_tx != 8'd0) wait_tx(tgt, $sformatf("vec%0d", v));
      repeat (3) tick();
      chk($sformatf("vec%0d_wr_count", v), wr_q.size(), {24'd0, vecs[v].exp_wr});
      chk($sformatf("vec%0d_rd_count", v), rd_q.size(), {24'd0, vecs[v].exp_rd});
      chk($sformatf("vec%0d_tx_count", v), tx_q.size(), {24'd0, vecs[v].exp_tx});
      chk($sformatf("vec%0d_err_count", v), n_err - base_err, {24'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
      if (vecs[v].exp_wr != 8'd0 && wr_q.size() > 0) begin
        chk($sformatf("vec%0d_last_wr", v), {17'd0, wr_q[$]}, {17'd0, vecs[v].exp_addr, vecs[v].exp_last});
      end
      if (vecs[v].exp_rd != 8'd0 && rd_q.size() > 0) begin
        chk($sformatf("vec%0d_last_rd_addr", v), {25'd0, rd_q[$]}, {25'd0, vecs[v].exp_addr});
      end
      if (vecs[v].exp_tx != 8'd0 && tx_q.size() > 0) begin
        chk($sformatf("vec%0d_last_tx", v), {24'd0, tx_q[$]}, {24'd0, vecs[v].exp_last});
      end
      if (vecs[v].exp_tx > 8'd1 && tx_cyc.size() > 1) begin
        chk($sformatf("vec%0d_tx_spacing", v), tx_cyc[1] - tx_cyc[0], RD_LAT + 2);
      end
    end

    // Backpressure on the second byte with an overrun during the stall.
    clear_obs();
    base_err = n_err;
    tgt = n_tx;
    tx_ready = 1'b1;
    send_byte(8'h85, 1'b0);
    send_byte(8'h03, 1'b0);
    wait_tx(tgt + 1, "bp_first");
    tx_ready = 1'b0;
    wait_valid("bp_second");
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("bp_hold_valid%0d", s), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("bp_hold_data%0d", s), {24'd0, tx_data}, 32'h46);
      if (s == 1) begin
        rx_data_valid = 1'b1;
        rx_data = 8'h55;
      end
      tick();
      rx_data_valid = 1'b0;
    end
    tx_ready = 1'b1;
    wait_tx(tgt + 3, "bp_all");
    repeat (3) tick();
    chk("bp_tx_count", tx_q.size(), 32'd3);
    chk("bp_rd_count", rd_q.size(), 32'd3);
    chk("bp_overrun_err", n_err - base_err, 32'd1);
    chk("bp_wr_none", wr_q.size(), 32'd0);
    for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
      chk($sformatf("bp_tx%0d", i), {24'd0, tx_q[i]}, 32'h45 + i);
    end

    // Asynchronous reset while a tx byte is pending.
    clear_obs();
    tx_ready = 1'b0;
    send_byte(8'h85, 1'b0);
    send_byte(8'h03, 1'b0);
    wait_valid("rst_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {4'd0, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, tx_data, busy, err}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tx_ready = 1'b1;
    clear_obs();
    base_err = n_err;
    repeat (6) tick();
    chk("rst_quiet_bus", wr_q.size() + rd_q.size() + tx_q.size(), 32'd0);
    chk("rst_quiet_err", n_err - base_err, 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h99, 1'b0);
    send_to();
    repeat (3) tick();
    chk("rst_fresh_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("rst_fresh_wr", {17'd0, wr_q[0]}, {17'd0, 7'h01, 8'h99});

    // Random command blocks against the transaction model.
    clear_obs();
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_tx_q.delete();
    base_err = n_err;
    k = 0;
    ready_rand = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      kind = $urandom_range(0, 3);
      a = 7'($urandom_range(0, 127));
      ai = int'(a);
      coin = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          len = $urandom_range(0, 5);
          send_byte({1'b0, a}, 1'b0);
          for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            exp_wr_q.push_back({7'((ai + i) % 128), d});
            send_byte(d, coin && (i == len - 1));
          end
          if (!(coin && len > 0)) send_to();
        end
        1: begin
          len = $urandom_range(0, 5);
          send_byte({1'b1, a}, 1'b0);
          tgt = n_tx + len;
          send_byte(8'(len), 1'b0);
          for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(7'((ai + i) % 128));
            exp_tx_q.push_back(rdata_of(7'((ai + i) % 128)));
          end
          if (len > 0) begin
            if (coin) begin
              rx_data_valid = 1'b1;
              rx_data = 8'($urandom);
              rx_block_timeout = 1'($urandom_range(0, 1));
              tick();
              rx_data_valid = 1'b0;
              rx_block_timeout = 1'b0;
              k++;
            end
            wait_tx(tgt, $sformatf("rand%0d", blk));
          end else if (coin) begin
            send_to();
          end
        end
        2: begin
          send_byte({1'b1, a}, 1'b0);
          send_to();
          k++;
        end
        default: send_to();
      endcase
      repeat ($urandom_range(1, 3)) tick();
    end
    ready_rand = 1'b0;
    tx_ready = 1'b1;
    repeat (4) tick();

    chk("rand_wr_count", wr_q.size(), exp_wr_q.size());
    chk("rand_rd_count", rd_q.size(), exp_rd_q.size());
    chk("rand_tx_count", tx_q.size(), exp_tx_q.size());
    chk("rand_err_count", n_err - base_err, k);
    for (int i = 0; i < exp_wr_q.size() && i < wr_q.size(); i++)
      chk($sformatf("rand_wr%0d", i), {17'd0, wr_q[i]}, {17'd0, exp_wr_q[i]});
    for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
      chk($sformatf("rand_rd%0d", i), {25'd0, rd_q[i]}, {25'd0, exp_rd_q[i]});
    for (int i = 0; i < exp_tx_q.size() && i < tx_q.size(); i++)
      chk($sformatf("rand_tx%0d", i), {24'd0, tx_q[i]}, {24'd0, exp_tx_q[i]});
    chk("rand_final_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
